// File: rtl/aes128_inv_keyshift_unit.sv
// AES-128 inverse-cipher front end: sequential key expansion into an 11-entry
// round-key store, then optional InvShiftRows followed by AddRoundKey.
module aes128_inv_keyshift_unit #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         key_ready,
  input  logic         in_valid,
  input  logic         isr_en,
  input  logic [3:0]   rk_idx,
  input  logic [127:0] state_in,
  output logic         out_valid,
  output logic [127:0] state_out
);

  localparam logic [3:0] LAST_RK = 4'(NR);

  // Forward S-box, one 16-byte row per entry; row = high nibble, column = low nibble.
  localparam logic [0:15][127:0] SBOX_ROWS = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef logic [0:15][7:0] state_bytes_t;
  typedef logic [0:3][31:0] key_words_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [6:0] sh;
    sh = {b[3:0], 3'b000};
    return SBOX_ROWS[b[7:4]][7'd127 - sh -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_round_key(input logic [127:0] rk, input logic [7:0] rc);
    key_words_t w;
    key_words_t n;
    logic [31:0] t;
    w = rk;
    // SubWord(RotWord(w3)) with the round constant folded into the top byte.
    t = {sbox(w[3][23:16]) ^ rc, sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])};
    n[0] = w[0] ^ t;
    n[1] = w[1] ^ n[0];
    n[2] = w[2] ^ n[1];
    n[3] = w[3] ^ n[2];
    return n;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    state_bytes_t in_b;
    state_bytes_t out_b;
    in_b = s;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        out_b[r + 4*c] = in_b[r + 4*((c - r + 4) % 4)];
      end
    end
    return out_b;
  endfunction

  logic [127:0] rk_q [0:NR];
  logic [127:0] rk_d [0:NR];
  logic [3:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         key_ready_q, key_ready_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] state_out_q, state_out_d;

  logic         start_acc;
  logic [3:0]   sel_idx;

  assign start_acc = start & ~busy_q;
  assign sel_idx   = (rk_idx > LAST_RK) ? LAST_RK : rk_idx;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    rk_d        = rk_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    key_ready_d = key_ready_q;
    out_valid_d = 1'b0;
    state_out_d = state_out_q;

    if (start_acc) begin
      rk_d[0]     = key;
      cnt_d       = 4'd1;
      busy_d      = 1'b1;
      key_ready_d = 1'b0;
    end else if (busy_q) begin
      rk_d[cnt_q] = next_round_key(rk_q[cnt_q - 4'd1], rcon(cnt_q));
      cnt_d       = cnt_q + 4'd1;
      if (cnt_q == LAST_RK) begin
        busy_d      = 1'b0;
        key_ready_d = 1'b1;
      end
    end

    // A start accepted this cycle invalidates the store, so a coincident request is dropped.
    if (in_valid && key_ready_q && !start_acc) begin
      out_valid_d = 1'b1;
      state_out_d = (isr_en ? inv_shift_rows(state_in) : state_in) ^ rk_q[sel_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the key store is cleared as well, so no key material survives a reset.
      rk_q        <= '{default: '0};
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      state_out_q <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
      rk_q        <= rk_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      key_ready_q <= key_ready_d;
      out_valid_q <= out_valid_d;
      state_out_q <= state_out_d;
    end
  end

  assign busy      = busy_q;
  assign key_ready = key_ready_q;
  assign out_valid = out_valid_q;
  assign state_out = state_out_q;

endmodule

// File: tb/tb_aes128_inv_keyshift_unit.sv
// Bench for aes128_inv_keyshift_unit: known-answer vectors, boundary cases and
// randomized requests against a byte-level FIPS-197 model built from GF(2^8) arithmetic.
module tb_aes128_inv_keyshift_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         key_ready;
  logic         in_valid;
  logic         isr_en;
  logic [3:0]   rk_idx;
  logic [127:0] state_in;
  logic         out_valid;
  logic [127:0] state_out;

  aes128_inv_keyshift_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .busy      (busy),
    .key_ready (key_ready),
    .in_valid  (in_valid),
    .isr_en    (isr_en),
    .rk_idx    (rk_idx),
    .state_in  (state_in),
    .out_valid (out_valid),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sb [256];
  logic [127:0] mrk [11];
  logic [127:0] exp_state;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = 32'(k >> (96 - 32*i));
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) mrk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  function automatic logic [127:0] isr_model(input logic [127:0] s);
    logic [7:0]   ib [16];
    logic [7:0]   ob [16];
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) ib[i] = 8'(s >> (8*(15 - i)));
    for (int r_ = 0; r_ < 4; r_++)
      for (int c = 0; c < 4; c++)
        ob[r_ + 4*c] = ib[r_ + 4*((c - r_ + 4) % 4)];
    for (int i = 0; i < 16; i++) r = {r[119:0], ob[i]};
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the start edge until key_ready; expected is 10.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!key_ready && n < 40) begin
      step();
      n++;
    end
    check(tag, 128'(n), 128'd10);
    check({tag, "_busy"}, 128'(busy), 128'd0);
  endtask

  task automatic run_key(input logic [127:0] k);
    key   = k;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", 128'(busy), 128'd1);
    check("kr_after_start", 128'(key_ready), 128'd0);
    expand(k);
    wait_ready("ready_latency");
  endtask

  task automatic req(input logic isr, input logic [3:0] idx, input logic [127:0] st);
    int eidx;
    in_valid = 1'b1;
    isr_en   = isr;
    rk_idx   = idx;
    state_in = st;
    step();
    in_valid = 1'b0;
    eidx = (idx > 4'd10) ? 10 : int'(idx);
    exp_state = (isr ? isr_model(st) : st) ^ mrk[eidx];
    check("req_valid", 128'(out_valid), 128'd1);
    check("req_state", state_out, exp_state);
  endtask

  initial begin
    build_sbox();
    rst = 1'b1; start = 1'b0; key = '0; in_valid = 1'b0;
    isr_en = 1'b0; rk_idx = '0; state_in = '0;
    exp_state = '0;
    step();
    step();
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_key_ready", 128'(key_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_state_out", state_out, 128'd0);
    rst = 1'b0;

    // Request before any key is ready is dropped.
    in_valid = 1'b1; state_in = rand128();
    step();
    in_valid = 1'b0;
    check("early_req_valid", 128'(out_valid), 128'd0);
    check("early_req_state", state_out, 128'd0);

    // FIPS-197 key 2b7e...
    run_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    req(1'b0, 4'd1, '0);
    check("kat_rk1", state_out, 128'ha0fafe1788542cb123a339392a6c7605);
    step();
    check("one_cycle_valid", 128'(out_valid), 128'd0);
    check("state_hold", state_out, exp_state);
    req(1'b0, 4'd10, '0);
    check("kat_rk10_a", state_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Key 000102...
    run_key(128'h000102030405060708090a0b0c0d0e0f);
    req(1'b0, 4'd10, '0);
    check("kat_rk10_b", state_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    req(1'b0, 4'd10, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("kat_ark", state_out, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
    req(1'b0, 4'd15, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("kat_clamp15", state_out, 128'h7ad5fda789ef4e272bca100b3d9ff59f);

    // All-zero key: rk0 = 0 isolates InvShiftRows.
    run_key('0);
    req(1'b1, 4'd0, 128'h00112233445566778899aabbccddeeff);
    check("kat_isr1", state_out, 128'h00ddaa774411eebb885522ffcc996633);
    req(1'b1, 4'd0, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
    check("kat_isr2", state_out, 128'h7a9f102789d5f50b2beffd9f3dca4ea7);

    // Restart while key_ready with a coincident request: request dropped.
    key = rand128(); start = 1'b1; in_valid = 1'b1; state_in = rand128();
    step();
    start = 1'b0; in_valid = 1'b0;
    check("restart_drop_valid", 128'(out_valid), 128'd0);
    check("restart_drop_state", state_out, exp_state);
    check("restart_kr_low", 128'(key_ready), 128'd0);
    check("restart_busy", 128'(busy), 128'd1);
    expand(key);
    wait_ready("restart_latency");
    req(1'b1, 4'd7, rand128());

    // Start while busy is ignored; expansion finishes on the original key.
    begin
      logic [127:0] ka;
      int n;
      ka = rand128();
      key = ka; start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!key_ready && n < 40) begin
        if (n == 3) begin
          key = rand128();
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        step();
        n++;
      end
      start = 1'b0;
      check("busy_start_latency", 128'(n), 128'd10);
      expand(ka);
      req(1'b0, 4'd10, '0);
      req(1'b1, 4'd4, rand128());
    end

    // Reset in the middle of an expansion.
    key = rand128(); start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_state = '0;
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_key_ready", 128'(key_ready), 128'd0);
    check("midrst_state", state_out, 128'd0);
    in_valid = 1'b1; state_in = rand128();
    step();
    in_valid = 1'b0;
    check("midrst_req_drop", 128'(out_valid), 128'd0);

    // Randomized back-to-back traffic against the model.
    for (int k = 0; k < 3; k++) begin
      run_key(rand128());
      for (int c = 0; c < 40; c++) begin
        logic         v;
        logic         e;
        logic [3:0]   ix;
        logic [127:0] st;
        int           eidx;
        v  = 1'($urandom_range(0, 1));
        e  = 1'($urandom_range(0, 1));
        ix = 4'($urandom_range(0, 15));
        st = rand128();
        in_valid = v; isr_en = e; rk_idx = ix; state_in = st;
        step();
        if (v) begin
          eidx = (ix > 4'd10) ? 10 : int'(ix);
          exp_state = (e ? isr_model(st) : st) ^ mrk[eidx];
        end
        check("rand_valid", 128'(out_valid), 128'(v));
        check("rand_state", state_out, exp_state);
      end
      in_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
